// File: rtl/score_tracker.sv
// score_tracker
//   Counts pipes cleared by the bird during a game and saturates at MAX_SCORE.
//   Keeps the best score seen since reset, and flags a new record when a game
//   ends above the previous best.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   game_start  in   start/restart request (level)
//   pipe_passed in   high while the bird is inside a pipe scoring window
//   game_over   in   collision / end of game (level, honoured only in PLAY)
//   score       out  current game score (registered)
//   high_score  out  best score since reset (registered)
//   new_record  out  last finished game beat the previous high score
//   playing     out  FSM is in PLAY (decoded from the state register)
module score_tracker #(
   parameter int SCORE_W      = 8,
   parameter int MAX_SCORE    = 255,
   parameter int PTS_PER_PIPE = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               game_start,
   input  logic               pipe_passed,
   input  logic               game_over,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score,
   output logic               new_record,
   output logic               playing
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   localparam logic [SCORE_W:0]   PTS_EXT = (SCORE_W+1)'(PTS_PER_PIPE);
   localparam logic [SCORE_W:0]   MAX_EXT = (SCORE_W+1)'(MAX_SCORE);
   localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(MAX_SCORE);

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] high_q,  high_d;
   logic               rec_q,   rec_d;
   logic               pipe_q;
   logic               pass_edge;

   // The sum is formed one bit wider so a score near the top of the range
   // cannot wrap before it is compared against the ceiling.
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s);
      logic [SCORE_W:0] sum;
      sum = {1'b0, s} + PTS_EXT;
      if (sum > MAX_EXT) return MAX_VAL;
      else               return sum[SCORE_W-1:0];
   endfunction

   // One point per rising edge of pipe_passed, however long it stays high.
   assign pass_edge = pipe_passed & ~pipe_q;

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      high_d  = high_q;
      rec_d   = rec_q;
      unique case (state_q)
         IDLE, OVER: begin
            // game_over is deliberately ignored here; only a start moves on.
            if (game_start) begin
               state_d = PLAY;
               score_d = '0;
               rec_d   = 1'b0;
            end
         end
         PLAY: begin
            if (game_over) begin
               // The final score is latched as-is; a coincident edge is dropped.
               state_d = OVER;
               if (score_q > high_q) begin
                  high_d = score_q;
                  rec_d  = 1'b1;
               end else begin
                  rec_d  = 1'b0;
               end
            end else if (pass_edge) begin
               score_d = sat_add(score_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         score_q <= '0;
         high_q  <= '0;
         rec_q   <= 1'b0;
         pipe_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         high_q  <= high_d;
         rec_q   <= rec_d;
         pipe_q  <= pipe_passed;
      end
   end

   assign score      = score_q;
   assign high_score = high_q;
   assign new_record = rec_q;
   assign playing    = (state_q == PLAY);

endmodule

// File: tb/tb_score_tracker.sv
module tb_score_tracker;

   logic       clk = 1'b0;
   logic       reset, game_start, pipe_passed, game_over;
   logic [7:0] score, high_score;
   logic       new_record, playing;

   int checks = 0;
   int errors = 0;

   score_tracker #(.SCORE_W(8), .MAX_SCORE(255), .PTS_PER_PIPE(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .game_start (game_start),
      .pipe_passed(pipe_passed),
      .game_over  (game_over),
      .score      (score),
      .high_score (high_score),
      .new_record (new_record),
      .playing    (playing)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic       rst, gs, pp, go;
      logic [7:0] e_score, e_high;
      logic       e_rec, e_play;
   } vec_t;

   vec_t vecs[28];

   task automatic cyc(input logic r, input logic s, input logic p, input logic o);
      reset = r; game_start = s; pipe_passed = p; game_over = o;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input int s, input int h, input int r, input int p);
      chk({name, ".score"},      int'(score),      s);
      chk({name, ".high_score"}, int'(high_score), h);
      chk({name, ".new_record"}, int'(new_record), r);
      chk({name, ".playing"},    int'(playing),    p);
   endtask

   task automatic pulses(input int n);
      for (int k = 0; k < n; k++) begin
         cyc(0, 0, 1, 0);
         cyc(0, 0, 0, 0);
      end
   endtask

   initial begin
      reset = 1'b1; game_start = 1'b0; pipe_passed = 1'b0; game_over = 1'b0;

      //           rst gs pp go  score high rec play
      vecs[0]  = '{1, 0, 0, 0,   0,   0,  0,  0};
      vecs[1]  = '{0, 0, 0, 0,   0,   0,  0,  0};
      vecs[2]  = '{0, 1, 0, 0,   0,   0,  0,  1};
      vecs[3]  = '{0, 0, 1, 0,   1,   0,  0,  1};
      vecs[4]  = '{0, 0, 1, 0,   1,   0,  0,  1};
      vecs[5]  = '{0, 0, 0, 0,   1,   0,  0,  1};
      vecs[6]  = '{0, 0, 1, 0,   2,   0,  0,  1};
      vecs[7]  = '{0, 0, 0, 0,   2,   0,  0,  1};
      vecs[8]  = '{0, 0, 1, 0,   3,   0,  0,  1};
      vecs[9]  = '{0, 0, 0, 1,   3,   3,  1,  0};
      vecs[10] = '{0, 0, 0, 1,   3,   3,  1,  0};
      vecs[11] = '{0, 0, 1, 0,   3,   3,  1,  0};
      vecs[12] = '{0, 1, 1, 0,   0,   3,  0,  1};
      vecs[13] = '{0, 0, 1, 0,   0,   3,  0,  1};
      vecs[14] = '{0, 0, 0, 0,   0,   3,  0,  1};
      vecs[15] = '{0, 0, 1, 0,   1,   3,  0,  1};
      vecs[16] = '{0, 0, 0, 0,   1,   3,  0,  1};
      vecs[17] = '{0, 0, 1, 0,   2,   3,  0,  1};
      vecs[18] = '{0, 0, 0, 0,   2,   3,  0,  1};
      vecs[19] = '{0, 0, 1, 0,   3,   3,  0,  1};
      vecs[20] = '{0, 0, 0, 1,   3,   3,  0,  0};
      vecs[21] = '{0, 1, 0, 0,   0,   3,  0,  1};
      vecs[22] = '{0, 0, 1, 0,   1,   3,  0,  1};
      vecs[23] = '{0, 0, 0, 0,   1,   3,  0,  1};
      vecs[24] = '{0, 0, 1, 1,   1,   3,  0,  0};
      vecs[25] = '{1, 0, 0, 0,   0,   0,  0,  0};
      vecs[26] = '{0, 1, 0, 1,   0,   0,  0,  1};
      vecs[27] = '{0, 1, 0, 0,   0,   0,  0,  1};

      for (int i = 0; i < 28; i++) begin
         cyc(vecs[i].rst, vecs[i].gs, vecs[i].pp, vecs[i].go);
         chk_all($sformatf("vec%0d", i), vecs[i].e_score, vecs[i].e_high,
                 vecs[i].e_rec, vecs[i].e_play);
      end

      // Reset, long idle, then start.
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
      chk_all("idle10", 0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      chk_all("start", 0, 0, 0, 1);

      // Three long pulses: exactly one point each, visible right after the rise.
      for (int p = 0; p < 3; p++) begin
         cyc(0, 0, 1, 0);
         chk($sformatf("long_pulse%0d_rise", p), int'(score), p + 1);
         for (int i = 0; i < 19; i++) cyc(0, 0, 1, 0);
         for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
      end
      chk("long_pulses_total", int'(score), 3);

      // Record / tie / record sequence.
      cyc(0, 0, 0, 1);
      chk_all("over3", 3, 3, 1, 0);
      cyc(0, 1, 0, 0); pulses(5); cyc(0, 0, 0, 1);
      chk_all("rec5", 5, 5, 1, 0);
      cyc(0, 1, 0, 0);
      chk_all("restart_clears_rec", 0, 5, 0, 1);
      pulses(5); cyc(0, 0, 0, 1);
      chk_all("tie5", 5, 5, 0, 0);
      cyc(0, 1, 0, 0); pulses(7); cyc(0, 0, 0, 1);
      chk_all("rec7", 7, 7, 1, 0);

      // Edge coincident with game_over: the edge is not counted.
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0); pulses(4);
      cyc(0, 0, 1, 1);
      chk_all("edge_and_over", 4, 4, 1, 0);

      // Reset in the middle of a game wipes everything, high score included.
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0); pulses(12); cyc(0, 0, 0, 1);
      chk_all("high12", 12, 12, 1, 0);
      cyc(0, 1, 0, 0); pulses(9);
      chk_all("score9", 9, 12, 0, 1);
      cyc(1, 0, 0, 0);
      chk_all("mid_reset", 0, 0, 0, 0);
      pulses(1);
      chk_all("pulse_in_idle", 0, 0, 0, 0);

      // Saturation at 255 with no wrap.
      cyc(0, 1, 0, 0);
      pulses(254);
      chk("sat_254", int'(score), 254);
      pulses(1);
      chk("sat_255", int'(score), 255);
      pulses(5);
      chk_all("sat_hold", 255, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk_all("sat_over", 255, 255, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/score_tracker.md
Name: score_tracker

Overview:
- Upstream producer of the 8-bit score consumed by the seven-segment score display.
- Counts pipes cleared by the bird, saturating at a programmable maximum.
- Tracks a high score across games and flags a new record at game over.
- Driven by game-logic event strobes and runs in the 50 MHz system clock domain.

Parameters:
- SCORE_W, 8: width of score and high_score. Must match the display input width.
- MAX_SCORE, 255: saturation ceiling. Must satisfy MAX_SCORE <= 2^SCORE_W - 1.
- PTS_PER_PIPE, 1: points added per cleared pipe. Must satisfy 1 <= PTS_PER_PIPE <= MAX_SCORE.

Ports:
- clk, input, 1: system clock (50 MHz). All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- game_start, input, 1: start/restart request. Level-sampled each cycle.
- pipe_passed, input, 1: high while the bird is inside a pipe's scoring window. May stay high for many cycles.
- game_over, input, 1: collision/end indication. Level-sampled each cycle.
- score, output, SCORE_W: current game score. Registered.
- high_score, output, SCORE_W: best score since reset. Registered.
- new_record, output, 1: high when the last finished game set a strictly higher high score.
- playing, output, 1: high when in the PLAY state.

Behaviour:
- Reset (synchronous, highest priority): state=IDLE, score=0, high_score=0, new_record=0, pipe_q=0, playing=0.
- Reset asserted mid-game also clears high_score.
- pipe_q is a register holding pipe_passed from the previous cycle. It is updated every cycle in every state.
- pass_edge = pipe_passed & ~pipe_q. One point event per rising edge of pipe_passed.
- FSM states: IDLE, PLAY, OVER. playing = (state==PLAY), decoded from the state register.
- IDLE:
  - game_start=1 -> PLAY; score<=0; new_record<=0.
  - Otherwise hold state and all outputs.
- PLAY, evaluated with this priority:
  1. game_over=1 -> OVER. No increment this cycle, even if pass_edge=1.
     - On this same edge: if score > high_score, then high_score<=score and new_record<=1.
     - Otherwise high_score is unchanged and new_record<=0.
     - A tie is not a record.
  2. Else if pass_edge=1: score <= min(score + PTS_PER_PIPE, MAX_SCORE). Compute the sum at SCORE_W+1 bits to avoid wrap-around.
  3. Else hold.
  - game_start in PLAY is ignored.
- OVER:
  - score, high_score and new_record are frozen.
  - game_start=1 -> PLAY; score<=0; new_record<=0. high_score is retained.
  - game_over held high in OVER has no effect.
- Latency: score changes on the first rising clk edge at which pass_edge=1 is sampled. This is 1 cycle after pipe_passed rises.
- If pipe_passed is already high when PLAY is entered and pipe_q=1, no point is scored until pipe_passed falls and rises again.
- If pipe_passed rises on the same cycle as game_start, that edge is consumed while still in IDLE/OVER and scores nothing.
- At saturation: further pass_edges leave score at MAX_SCORE. No wrap to 0.
- game_start and game_over both high in IDLE: go to PLAY. game_over is evaluated only in PLAY.
- All outputs are driven directly from registers. There is no combinational path from inputs to outputs.

Test Plan:
- Reset, then idle 10 cycles -> score=0, high_score=0, new_record=0, playing=0. Then pulse game_start -> playing=1 on the next cycle, score=0.
- In PLAY, hold pipe_passed high for 20 cycles, then low, repeated 3 times -> score=3 (exactly one point per pulse). Each increment is visible 1 cycle after the rising edge.
- Run with MAX_SCORE=255 through 260 pipe pulses -> score reaches 255 and stays 255, with no wrap.
- Score 5, then game_over -> state OVER, high_score=5, new_record=1. Restart, score 5 again, game_over -> high_score=5, new_record=0 (tie). Restart, score 7, game_over -> high_score=7, new_record=1.
- Assert pipe_passed rising edge and game_over in the same cycle at score=4 -> final score=4, OVER entered, high_score updated using 4.
- Assert reset mid-PLAY at score=9 with high_score=12 -> next cycle all outputs are 0 and state is IDLE. A subsequent pipe pulse without game_start leaves score=0.
